// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the 32-bit bus datapath.
// The master side is the sequencer: it reads IR/CON_FF/Stop and drives every strobe.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;
  logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout;
  logic        MAR_enable, PC_enable, IR_enable, MDR_enable, Y_enable, ZLowIn, ZHighIn;
  logic        HI_enable, LO_enable, CON_enable, OutPort_enable;
  logic        MDR_read, RAM_write, IncPC;
  logic        Gra, Grb, Grc, R_in, R_out;
  logic [4:0]  ALU_op;
  logic        Run;
  logic [3:0]  state_dbg;

  modport master (
    input  IR, CON_FF, Stop,
    output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout,
    output MAR_enable, PC_enable, IR_enable, MDR_enable, Y_enable, ZLowIn, ZHighIn,
    output HI_enable, LO_enable, CON_enable, OutPort_enable,
    output MDR_read, RAM_write, IncPC,
    output Gra, Grb, Grc, R_in, R_out,
    output ALU_op, Run, state_dbg
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout,
    input  MAR_enable, PC_enable, IR_enable, MDR_enable, Y_enable, ZLowIn, ZHighIn,
    input  HI_enable, LO_enable, CON_enable, OutPort_enable,
    input  MDR_read, RAM_write, IncPC,
    input  Gra, Grb, Grc, R_in, R_out,
    input  ALU_op, Run, state_dbg
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode-selected execute T3-T7, Moore strobe decode.
// IR is read directly during execute, since it is only loaded at the end of T2.
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'b00011,
  parameter logic [4:0] NOP_OP = 5'b11001
) (
  input logic Clock,
  input logic Clear,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    C_ALU3, C_ADDI, C_LDI, C_MULDIV, C_LD, C_ST, C_BRCC,
    C_JR, C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT
  } op_class_t;

  state_t      state;
  logic [4:0]  opcode;
  op_class_t   cls;

  assign opcode = bus.IR[31:27];

  always_comb begin
    cls = C_NOP;
    case (opcode)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011, 5'b00100, 5'b01001, 5'b01010: cls = C_ALU3;
      5'b01011: cls = C_ADDI;
      5'b01110, 5'b01111: cls = C_MULDIV;
      5'b10010: cls = C_BRCC;
      5'b10011: cls = C_JR;
      5'b10101: cls = C_IN;
      5'b10110: cls = C_OUT;
      5'b10111: cls = C_MFHI;
      5'b11000: cls = C_MFLO;
      5'b11010: cls = C_HALT;
      NOP_OP:   cls = C_NOP;
      default:  cls = C_NOP;
    endcase
  end

  function automatic state_t last_state(input op_class_t c);
    case (c)
      C_ALU3, C_ADDI, C_LDI: return S_T5;
      C_MULDIV, C_BRCC:      return S_T6;
      C_LD, C_ST:            return S_T7;
      default:               return S_T3;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3, S_T4, S_T5, S_T6, S_T7: begin
          if (cls == C_HALT)                state <= S_HALTED;
          else if (state == last_state(cls)) state <= bus.Stop ? S_HALTED : S_T0;
          else                               state <= state_t'(state + 4'd1);
        end
        default: state <= S_HALTED;
      endcase
    end
  end

  always_comb begin
    bus.PCout = 1'b0; bus.ZLowout = 1'b0; bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.InPortout = 1'b0; bus.Cout = 1'b0;
    bus.BAout = 1'b0; bus.MAR_enable = 1'b0; bus.PC_enable = 1'b0; bus.IR_enable = 1'b0;
    bus.MDR_enable = 1'b0; bus.Y_enable = 1'b0; bus.ZLowIn = 1'b0; bus.ZHighIn = 1'b0;
    bus.HI_enable = 1'b0; bus.LO_enable = 1'b0; bus.CON_enable = 1'b0;
    bus.OutPort_enable = 1'b0; bus.MDR_read = 1'b0; bus.RAM_write = 1'b0; bus.IncPC = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.R_in = 1'b0; bus.R_out = 1'b0;
    bus.ALU_op = 5'd0;
    case (state)
      S_T0: begin bus.PCout = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1; bus.ZLowIn = 1'b1; end
      S_T1: begin bus.ZLowout = 1'b1; bus.PC_enable = 1'b1; bus.MDR_read = 1'b1; bus.MDR_enable = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IR_enable = 1'b1; end
      S_T3: begin
        case (cls)
          C_ALU3, C_ADDI: begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
          C_LDI, C_LD, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1; end
          C_MULDIV: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
          C_BRCC:   begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.CON_enable = 1'b1; end
          C_JR:     begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1; end
          C_MFHI:   begin bus.Gra = 1'b1; bus.R_in = 1'b1; bus.HIout = 1'b1; end
          C_MFLO:   begin bus.Gra = 1'b1; bus.R_in = 1'b1; bus.LOout = 1'b1; end
          C_IN:     begin bus.Gra = 1'b1; bus.R_in = 1'b1; bus.InPortout = 1'b1; end
          C_OUT:    begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.OutPort_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU3: begin bus.Grc = 1'b1; bus.R_out = 1'b1; bus.ZLowIn = 1'b1; bus.ALU_op = opcode; end
          C_ADDI, C_LDI, C_LD, C_ST: begin bus.Cout = 1'b1; bus.ZLowIn = 1'b1; bus.ALU_op = ADD_OP; end
          C_MULDIV: begin
            bus.Grb = 1'b1; bus.R_out = 1'b1; bus.ZLowIn = 1'b1; bus.ZHighIn = 1'b1;
            bus.ALU_op = opcode;
          end
          C_BRCC: begin bus.PCout = 1'b1; bus.Y_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU3, C_ADDI, C_LDI: begin bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          C_MULDIV: begin bus.ZLowout = 1'b1; bus.LO_enable = 1'b1; end
          C_LD, C_ST: begin bus.ZLowout = 1'b1; bus.MAR_enable = 1'b1; end
          C_BRCC: begin bus.Cout = 1'b1; bus.ZLowIn = 1'b1; bus.ALU_op = ADD_OP; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MULDIV: begin bus.ZHighout = 1'b1; bus.HI_enable = 1'b1; end
          C_LD:     begin bus.MDR_read = 1'b1; bus.MDR_enable = 1'b1; end
          C_ST:     begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.MDR_enable = 1'b1; end
          // Branch taken only when the condition flag holds during the write-back cycle.
          C_BRCC:   begin bus.ZLowout = 1'b1; bus.PC_enable = bus.CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          C_ST: bus.RAM_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.Run       = (state >= S_T0) && (state <= S_T7);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus random instruction streams checked cycle-by-cycle against
// a per-opcode table of expected strobe sets.
module tb_control_sequencer;
  localparam int W = 34;

  // Strobe bit positions within the 28-bit strobe field of an expected word
  localparam int B_PCOUT = 27, B_ZLOUT = 26, B_ZHOUT = 25, B_MDROUT = 24, B_HIOUT = 23;
  localparam int B_LOOUT = 22, B_INPOUT = 21, B_COUT = 20, B_BAOUT = 19, B_MAREN = 18;
  localparam int B_PCEN = 17, B_IREN = 16, B_MDREN = 15, B_YEN = 14, B_ZLIN = 13;
  localparam int B_ZHIN = 12, B_HIEN = 11, B_LOEN = 10, B_CONEN = 9, B_OUTEN = 8;
  localparam int B_MDRRD = 7, B_RAMWR = 6, B_INCPC = 5, B_GRA = 4, B_GRB = 3;
  localparam int B_GRC = 2, B_RIN = 1, B_ROUT = 0;
  localparam logic [4:0] ADD_CODE = 5'b00011;

  logic Clock;
  logic Clear;
  control_sequencer_if bus ();

  control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  int total = 0;
  int bad = 0;

  assign obs = {bus.ALU_op, bus.Run,
                bus.PCout, bus.ZLowout, bus.ZHighout, bus.MDRout, bus.HIout, bus.LOout,
                bus.InPortout, bus.Cout, bus.BAout, bus.MAR_enable, bus.PC_enable,
                bus.IR_enable, bus.MDR_enable, bus.Y_enable, bus.ZLowIn, bus.ZHighIn,
                bus.HI_enable, bus.LO_enable, bus.CON_enable, bus.OutPort_enable,
                bus.MDR_read, bus.RAM_write, bus.IncPC, bus.Gra, bus.Grb, bus.Grc,
                bus.R_in, bus.R_out};

  function automatic logic [27:0] s(input int a, input int b = -1, input int c = -1,
                                    input int d = -1);
    logic [27:0] v = '0;
    v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  task automatic push(input logic [27:0] strobes, input logic [4:0] alu = 5'd0);
    exp_q.push_back({alu, 1'b1, strobes});
  endtask

  task automatic check(input string tag, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: one expected word per cycle from T0 to the last execute state.
  // Returns 1 when the instruction itself halts the machine.
  task automatic build(input logic [31:0] ir, input bit con, output bit halts);
    logic [4:0] op = ir[31:27];
    halts = 1'b0;
    push(s(B_PCOUT, B_MAREN, B_INCPC, B_ZLIN));
    push(s(B_ZLOUT, B_PCEN, B_MDRRD, B_MDREN));
    push(s(B_MDROUT, B_IREN));
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
        push(s(B_GRB, B_ROUT, B_YEN));
        push(s(B_GRC, B_ROUT, B_ZLIN), op);
        push(s(B_ZLOUT, B_GRA, B_RIN));
      end
      5'b01011, 5'b00001: begin
        push(s(B_GRB, (op == 5'b00001) ? B_BAOUT : B_ROUT, B_YEN));
        push(s(B_COUT, B_ZLIN), ADD_CODE);
        push(s(B_ZLOUT, B_GRA, B_RIN));
      end
      5'b01110, 5'b01111: begin
        push(s(B_GRA, B_ROUT, B_YEN));
        push(s(B_GRB, B_ROUT, B_ZLIN, B_ZHIN), op);
        push(s(B_ZLOUT, B_LOEN));
        push(s(B_ZHOUT, B_HIEN));
      end
      5'b00000, 5'b00010: begin
        push(s(B_GRB, B_BAOUT, B_YEN));
        push(s(B_COUT, B_ZLIN), ADD_CODE);
        push(s(B_ZLOUT, B_MAREN));
        if (op == 5'b00000) begin
          push(s(B_MDRRD, B_MDREN));
          push(s(B_MDROUT, B_GRA, B_RIN));
        end else begin
          push(s(B_GRA, B_ROUT, B_MDREN));
          push(s(B_RAMWR));
        end
      end
      5'b10010: begin
        push(s(B_GRA, B_ROUT, B_CONEN));
        push(s(B_PCOUT, B_YEN));
        push(s(B_COUT, B_ZLIN), ADD_CODE);
        push(con ? s(B_ZLOUT, B_PCEN) : s(B_ZLOUT));
      end
      5'b10011: push(s(B_GRA, B_ROUT, B_PCEN));
      5'b10111: push(s(B_GRA, B_RIN, B_HIOUT));
      5'b11000: push(s(B_GRA, B_RIN, B_LOOUT));
      5'b10101: push(s(B_GRA, B_RIN, B_INPOUT));
      5'b10110: push(s(B_GRA, B_ROUT, B_OUTEN));
      5'b11010: begin push(28'd0); halts = 1'b1; end
      default:  push(28'd0);
    endcase
  endtask

  // Entered and left at posedge+1. Asserts Clear low after step abort_at (if >= 0).
  task automatic run_instr(input logic [31:0] ir, input bit con, input bit stp,
                           input int abort_at, output bit halted);
    bit halts;
    int n;
    exp_q.delete();
    build(ir, con, halts);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      bus.IR = ir;
      bus.CON_FF = con;
      if (k == n - 1)  bus.Stop = stp;
      else if (k < 3)  bus.Stop = 1'($urandom_range(0, 1));
      else             bus.Stop = 1'b0;
      #2;
      check($sformatf("op%05b_step%0d", ir[31:27], k), exp_q.pop_front());
      if (k == abort_at) Clear = 1'b0;
      @(posedge Clock); #1;
      if (k == abort_at) break;
    end
    bus.Stop = 1'b0;
    halted = (abort_at < 0) && (halts || stp);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.Stop = 1'($urandom_range(0, 1));
      bus.CON_FF = 1'($urandom_range(0, 1));
      #2;
      check($sformatf("%s_%0d", tag, i), '0);
      @(posedge Clock); #1;
    end
    bus.Stop = 1'b0;
  endtask

  task automatic do_reset();
    Clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #3;
      check($sformatf("reset_%0d", i), '0);
    end
    Clear = 1'b1;
    #1;
    check("reset_release", '0);
    @(posedge Clock); #1;
  endtask

  bit halted;
  logic [31:0] rir;
  bit rcon, rstp;

  initial begin
    Clear = 1'b0;
    bus.IR = 32'd0;
    bus.CON_FF = 1'b0;
    bus.Stop = 1'b0;
    do_reset();

    run_instr(32'hC1000000, 1'b0, 1'b0, -1, halted);   // mflo
    run_instr(32'h18A20000, 1'b0, 1'b0, -1, halted);   // add
    run_instr(32'h00800055, 1'b0, 1'b0, -1, halted);   // ld
    run_instr(32'h10800055, 1'b0, 1'b0, -1, halted);   // st
    run_instr(32'h90800004, 1'b0, 1'b0, -1, halted);   // brcc not taken
    run_instr(32'h90800004, 1'b1, 1'b0, -1, halted);   // brcc taken
    run_instr(32'h71180000, 1'b0, 1'b0, -1, halted);   // mul
    run_instr(32'hF8000000, 1'b0, 1'b0, -1, halted);   // undefined opcode -> nop

    run_instr(32'h00800055, 1'b0, 1'b0, 5, halted);    // Clear during T5 of ld
    #2;
    check("clear_mid_ld", '0);
    Clear = 1'b1;
    @(posedge Clock); #1;

    run_instr(32'hD0000000, 1'b0, 1'b0, -1, halted);   // halt
    check_idle("halt_op", 10);
    do_reset();

    run_instr(32'h18A20000, 1'b0, 1'b1, -1, halted);   // Stop in last execute state
    check_idle("stop", 10);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      rir  = $urandom;
      rcon = 1'($urandom_range(0, 1));
      rstp = ($urandom_range(0, 7) == 0);
      run_instr(rir, rcon, rstp, -1, halted);
      if (halted) begin
        check_idle($sformatf("rand_halt%0d", i), 3);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit bus datapath.
- Drives every control strobe the datapath consumes, cycle by cycle, through fetch states T0–T2 and execute states T3–T7.
- Decodes IR[31:27] to choose the execute sequence.
- Replaces the hand-written per-instruction state sequencing currently done in benches.

Parameters:
- ADD_OP, 5'b00011, ALU_op code emitted for address/offset/branch-target adds.
- NOP_OP, 5'b11001, opcode treated as no-operation; undefined opcodes map here.

Ports:
- Clock  input  1  system clock, rising-edge.
- Clear  input  1  reset; synchronous, active-low.
- IR  input  32  instruction register contents; opcode = IR[31:27].
- CON_FF  input  1  branch-condition flag from the datapath CON logic.
- Stop  input  1  request to halt at the next instruction boundary.
- PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout  output  1 each  bus-source selects.
- MAR_enable, PC_enable, IR_enable, MDR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable, LO_enable, CON_enable, OutPort_enable  output  1 each  register load enables.
- MDR_read, RAM_write, IncPC  output  1 each  memory and PC controls.
- Gra, Grb, Grc, R_in, R_out  output  1 each  register-file select/enable.
- ALU_op  output  5  ALU operation code.
- Run  output  1  high while executing; low in Reset and Halted.

Behaviour:
- State register: Reset, T0..T7, Halted. Every state lasts exactly one clock.
- Outputs are a Moore decode of the present state, plus IR for ALU_op. A signal is asserted for the whole cycle its state is present and is 0 unless listed.
- Clear low at a rising edge: state becomes Reset; all outputs 0; Run 0; ALU_op 0. Takes effect mid-instruction with no completion of the pending sequence. First edge with Clear high: Reset to T0.
- Fetch, all opcodes:
  - T0: PCout, MAR_enable, IncPC, ZLowIn.
  - T1: ZLowout, PC_enable, MDR_read, MDR_enable.
  - T2: MDRout, IR_enable.
- IR is sampled at T3 and must be stable T3..end of execute.
- Opcodes, IR[31:27]: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, mul 01110, div 01111, brcc 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Any other code executes as nop.
- ALU_op = IR[31:27] in ALU states of add/sub/and/or/mul/div. ALU_op = ADD_OP for addi/ld/ldi/st/brcc adds. ALU_op = 0 elsewhere.
- Execute sequences (the last listed state returns to T0):
  - add/sub/and/or:
    - T3: Grb, R_out, Y_enable.
    - T4: Grc, R_out, ZLowIn.
    - T5: ZLowout, Gra, R_in.
  - addi:
    - T3: Grb, R_out, Y_enable.
    - T4: Cout, ZLowIn.
    - T5: ZLowout, Gra, R_in.
  - mul/div:
    - T3: Gra, R_out, Y_enable.
    - T4: Grb, R_out, ZLowIn, ZHighIn.
    - T5: ZLowout, LO_enable.
    - T6: ZHighout, HI_enable.
  - ldi: T3–T5 same as addi, except T3 uses BAout instead of R_out.
  - ld:
    - T3: Grb, BAout, Y_enable.
    - T4: Cout, ZLowIn.
    - T5: ZLowout, MAR_enable.
    - T6: MDR_read, MDR_enable.
    - T7: MDRout, Gra, R_in.
  - st:
    - T3–T5: same as ld.
    - T6: Gra, R_out, MDR_enable (MDR_read 0).
    - T7: RAM_write.
  - brcc:
    - T3: Gra, R_out, CON_enable.
    - T4: PCout, Y_enable.
    - T5: Cout, ZLowIn.
    - T6: ZLowout; PC_enable only if CON_FF=1 during T6.
  - jr: T3: Gra, R_out, PC_enable.
  - mfhi / mflo: T3: Gra, R_in, HIout / LOout respectively.
  - in: T3: Gra, R_in, InPortout.
  - out: T3: Gra, R_out, OutPort_enable.
  - nop: T3 with no strobes.
  - halt: T3 to Halted.
- Halted: all outputs 0, Run 0; stays until Clear low.
- Stop: sampled in the final execute state. If Stop=1, go to Halted instead of T0. Stop is ignored in fetch states.
- No two bus-source selects are ever asserted in the same state.

Test Plan:
- Clear low 2 cycles, then high -> all outputs 0 in Reset; first cycle after release is T0 with PCout=MAR_enable=IncPC=ZLowIn=1, Run=1.
- IR=32'hC1000000 (mflo R2) -> T3 asserts Gra=R_in=LOout=1 only; next cycle T0.
- IR=32'h18A20000 (add) -> T3 Grb/R_out/Y_enable, T4 Grc/R_out/ZLowIn with ALU_op=00011, T5 ZLowout/Gra/R_in; 6 cycles total.
- IR=32'h00800055 (ld) -> ALU_op=00011 in T4, MDR_read=MDR_enable=1 in T6, MDRout=R_in=1 in T7. Repeat with st -> RAM_write=1 only in T7.
- brcc with CON_FF=0, then CON_FF=1 -> PC_enable=0 vs 1 in T6. mul -> LO_enable in T5, HI_enable in T6.
- Clear low during T5 of ld -> next cycle Reset, all outputs 0. halt opcode, or Stop=1 in the last execute state -> Halted, Run=0, held for 10 cycles.
